// File: rtl/potato_axil_slave_regs_if.sv
// AXI4-Lite bus bundle for the potato S00_AXI register port.
interface potato_axil_slave_regs_if #(
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] S_AXI_AWADDR;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [31:0]       S_AXI_WDATA;
   logic [3:0]        S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [ADDR_W-1:0] S_AXI_ARADDR;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [31:0]       S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      output S_AXI_RREADY
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
      input  S_AXI_RREADY
   );
endinterface

// File: rtl/potato_axil_slave_regs.sv
// AXI4-Lite slave with four 32-bit R/W registers exported on reg_out.
// Optional macro POTATO_AXIL_SLVERR_EN: address bit 4 set returns SLVERR
// (write dropped, read data zero); otherwise bit 4 is ignored and addresses alias.
module potato_axil_slave_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   potato_axil_slave_regs_if.slave         s_axi,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out
);
   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned SW = DW / 8;
`ifdef POTATO_AXIL_SLVERR_EN
   localparam int unsigned AQ_W = 3;
`else
   localparam int unsigned AQ_W = 2;
`endif
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_COMMIT, WR_RESP
   } wr_state_e;

   wr_state_e         wr_state_q;
   logic [DW-1:0]     regs_q [4];
   logic              aw_full_q, w_full_q, bvalid_q;
   logic [AQ_W-1:0]   awaddr_q;
   logic [DW-1:0]     wdata_q;
   logic [SW-1:0]     wstrb_q;
   logic [1:0]        bresp_q;
   logic              rvalid_q;
   logic [DW-1:0]     rdata_q;
   logic [1:0]        rresp_q;

   logic [AW-1:0]     awaddr_bus_c, araddr_bus_c;
   logic              aw_hs_c, w_hs_c, aw_avail_c, w_avail_c, commit_c, b_done_c;
   logic [AQ_W-1:0]   wr_addr_c, rd_addr_c;
   logic [DW-1:0]     wr_data_c;
   logic [SW-1:0]     wr_strb_c;
   logic              wr_err_c, rd_err_c, ar_hs_c, arready_c;
   logic              unused_c;

   // Handshakes and commit source: buffered beat if held, else the live bus beat.
   assign awaddr_bus_c = s_axi.S_AXI_AWADDR;
   assign araddr_bus_c = s_axi.S_AXI_ARADDR;
   assign aw_hs_c    = s_axi.S_AXI_AWVALID && !aw_full_q;
   assign w_hs_c     = s_axi.S_AXI_WVALID && !w_full_q;
   assign aw_avail_c = aw_full_q || aw_hs_c;
   assign w_avail_c  = w_full_q || w_hs_c;
   assign commit_c   = aw_avail_c && w_avail_c && (wr_state_q != WR_RESP);
   assign b_done_c   = bvalid_q && s_axi.S_AXI_BREADY;
   assign wr_addr_c  = aw_full_q ? awaddr_q : awaddr_bus_c[AQ_W+1:2];
   assign wr_data_c  = w_full_q ? wdata_q : s_axi.S_AXI_WDATA;
   assign wr_strb_c  = w_full_q ? wstrb_q : s_axi.S_AXI_WSTRB;
   assign rd_addr_c  = araddr_bus_c[AQ_W+1:2];
`ifdef POTATO_AXIL_SLVERR_EN
   assign wr_err_c = wr_addr_c[2];
   assign rd_err_c = rd_addr_c[2];
`else
   assign wr_err_c = 1'b0;
   assign rd_err_c = 1'b0;
`endif
   assign arready_c = !rvalid_q || s_axi.S_AXI_RREADY;
   assign ar_hs_c   = s_axi.S_AXI_ARVALID && arready_c;
   assign unused_c  = ^{awaddr_bus_c, araddr_bus_c, s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

   // Write channel FSM: buffer AW/W beats, commit when both present and B is free.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_q <= WR_IDLE;
         aw_full_q  <= 1'b0;
         w_full_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         if (aw_hs_c) awaddr_q <= awaddr_bus_c[AQ_W+1:2];
         if (w_hs_c) begin
            wdata_q <= s_axi.S_AXI_WDATA;
            wstrb_q <= s_axi.S_AXI_WSTRB;
         end
         if (commit_c) begin
            if (!wr_err_c) begin
               for (int b = 0; b < int'(SW); b++) begin
                  if (wr_strb_c[b]) regs_q[wr_addr_c[1:0]][8*b +: 8] <= wr_data_c[8*b +: 8];
               end
            end
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
            wr_state_q <= WR_RESP;
         end else begin
            aw_full_q <= aw_avail_c;
            w_full_q  <= w_avail_c;
            if (b_done_c) bvalid_q <= 1'b0;
            if (bvalid_q && !b_done_c) begin
               wr_state_q <= WR_RESP;
            end else begin
               case ({aw_avail_c, w_avail_c})
                  2'b11:   wr_state_q <= WR_COMMIT;
                  2'b10:   wr_state_q <= WR_HAVE_AW;
                  2'b01:   wr_state_q <= WR_HAVE_W;
                  default: wr_state_q <= WR_IDLE;
               endcase
            end
         end
      end
   end

   // Read channel: load response on AR handshake, hold until RREADY.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs_c) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_err_c ? '0 : regs_q[rd_addr_c[1:0]];
         rresp_q  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.S_AXI_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign s_axi.S_AXI_AWREADY = !aw_full_q;
   assign s_axi.S_AXI_WREADY  = !w_full_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_c;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign reg_out = {regs_q[3], regs_q[2], regs_q[1], regs_q[0]};
endmodule

// File: tb/tb_potato_axil_slave_regs.sv
// Directed bench for potato_axil_slave_regs with B/R response scoreboards.
module tb_potato_axil_slave_regs;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] reg_out;
   int           n_checks = 0;
   int           n_errors = 0;
   logic [1:0]   bq[$];
   logic [33:0]  rq[$];
   logic [31:0]  mdl [4];

   potato_axil_slave_regs_if #(.ADDR_W(5)) bus ();

   potato_axil_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
      .ACLK(clk), .ARESETN(rst_n), .s_axi(bus.slave), .reg_out(reg_out));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic is_err(input logic [4:0] a);
`ifdef POTATO_AXIL_SLVERR_EN
      return a[4];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      bq.push_back(is_err(a) ? 2'b10 : 2'b00);
      if (!is_err(a)) mdl[a[3:2]] = merge(mdl[a[3:2]], d, s);
   endtask

   task automatic pop_b(input string tag);
      logic [1:0] e;
      chk({tag, "_bq_nonempty"}, 128'(bq.size() > 0), 128'(1));
      if (bq.size() > 0) begin
         e = bq.pop_front();
         chk({tag, "_bresp"}, 128'(bus.S_AXI_BRESP), 128'(e));
      end
   endtask

   task automatic pop_r(input string tag);
      logic [33:0] e;
      chk({tag, "_rq_nonempty"}, 128'(rq.size() > 0), 128'(1));
      if (rq.size() > 0) begin
         e = rq.pop_front();
         chk({tag, "_rdata"}, 128'(bus.S_AXI_RDATA), 128'(e[31:0]));
         chk({tag, "_rresp"}, 128'(bus.S_AXI_RRESP), 128'(e[33:32]));
      end
   endtask

   task automatic wait_b(input string tag);
      bus.S_AXI_BREADY = 1'b1;
      for (int i = 0; i < 50 && !bus.S_AXI_BVALID; i++) step();
      chk({tag, "_bvalid_seen"}, 128'(bus.S_AXI_BVALID), 128'(1));
      if (bus.S_AXI_BVALID) begin
         pop_b(tag);
         step();
      end
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_write(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      logic aw_acc, w_acc;
      model_write(a, d, s);
      bus.S_AXI_AWADDR = a;  bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = d;   bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
      for (int i = 0; i < 50 && (bus.S_AXI_AWVALID || bus.S_AXI_WVALID); i++) begin
         aw_acc = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         w_acc  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         step();
         if (aw_acc) bus.S_AXI_AWVALID = 1'b0;
         if (w_acc)  bus.S_AXI_WVALID = 1'b0;
      end
      chk({tag, "_accepted"}, 128'({bus.S_AXI_AWVALID, bus.S_AXI_WVALID}), 128'(0));
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      wait_b(tag);
   endtask

   task automatic axi_read(input string tag, input logic [4:0] a);
      rq.push_back(is_err(a) ? {2'b10, 32'h0} : {2'b00, mdl[a[3:2]]});
      bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < 50 && !bus.S_AXI_ARREADY; i++) step();
      step();
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b1;
      for (int i = 0; i < 50 && !bus.S_AXI_RVALID; i++) step();
      chk({tag, "_rvalid_seen"}, 128'(bus.S_AXI_RVALID), 128'(1));
      if (bus.S_AXI_RVALID) begin
         pop_r(tag);
         step();
      end
      bus.S_AXI_RREADY = 1'b0;
   endtask

   initial begin
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = '0;

      // Reset values.
      #2;
      chk("rst_readies", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(3'b111));
      chk("rst_valids", 128'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 128'(0));
      chk("rst_resps_rdata", 128'({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}), 128'(0));
      chk("rst_reg_out", reg_out, 128'(0));
      step(); step();
      rst_n = 1'b1;
      step();

      // Sequential write / read-back.
      for (int i = 0; i < 4; i++) axi_write("seq_wr", 5'(4*i), 32'(i + 1), 4'hF);
      for (int i = 0; i < 4; i++) axi_read("seq_rd", 5'(4*i));
      chk("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);

      // Byte strobes.
      axi_write("strb_full", 5'h4, 32'hFFFF_FFFF, 4'hF);
      axi_write("strb_part", 5'h4, 32'hAABB_CCDD, 4'b0101);
      axi_read("strb_rd", 5'h4);
      chk("strb_model", 128'(mdl[1]), 128'h FFBBFFDD);
      axi_write("strb_zero", 5'h4, 32'h1234_5678, 4'b0000);
      chk("strb_zero_reg", reg_out[63:32], 128'h FFBBFFDD);
      axi_read("alias_low_bits", 5'h6);

      // AW three cycles before W.
      model_write(5'h8, 32'h1234_5678, 4'hF);
      bus.S_AXI_AWADDR = 5'h8; bus.S_AXI_AWVALID = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      chk("awfirst_awready_low", 128'(bus.S_AXI_AWREADY), 128'(0));
      step(); step();
      chk("awfirst_no_b_yet", 128'(bus.S_AXI_BVALID), 128'(0));
      bus.S_AXI_WDATA = 32'h1234_5678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      step();
      bus.S_AXI_WVALID = 1'b0;
      chk("awfirst_b_latency", 128'(bus.S_AXI_BVALID), 128'(1));
      chk("awfirst_reg_out", reg_out[95:64], 128'h12345678);
      wait_b("awfirst");
      axi_read("awfirst_rd", 5'h8);

      // W three cycles before AW.
      model_write(5'h8, 32'hCAFE_F00D, 4'hF);
      bus.S_AXI_WDATA = 32'hCAFE_F00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      step();
      bus.S_AXI_WVALID = 1'b0;
      chk("wfirst_wready_low", 128'(bus.S_AXI_WREADY), 128'(0));
      step(); step();
      chk("wfirst_no_b_yet", 128'(bus.S_AXI_BVALID), 128'(0));
      bus.S_AXI_AWADDR = 5'h8; bus.S_AXI_AWVALID = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      chk("wfirst_b_latency", 128'(bus.S_AXI_BVALID), 128'(1));
      wait_b("wfirst");
      axi_read("wfirst_rd", 5'h8);

      // B backpressure with a second write queued behind it.
      model_write(5'h0, 32'h0000_00A5, 4'hF);
      bus.S_AXI_AWADDR = 5'h0; bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA = 32'h0000_00A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
      step();
      bus.S_AXI_AWADDR = 5'h4; bus.S_AXI_WDATA = 32'h0000_0077;
      step();
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      chk("bp_second_accepted", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 128'(0));
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid_held", 128'({bus.S_AXI_BVALID, bus.S_AXI_BRESP}), 128'(3'b100));
         chk("bp_reg1_not_committed", reg_out[63:32], 128'(mdl[1]));
         step();
      end
      pop_b("bp_first");
      bus.S_AXI_BREADY = 1'b1;
      step();
      bus.S_AXI_BREADY = 1'b0;
      chk("bp_gap_after_b", 128'(bus.S_AXI_BVALID), 128'(0));
      model_write(5'h4, 32'h0000_0077, 4'hF);
      step();
      chk("bp_second_committed", reg_out[63:0], {64'h0, mdl[1], mdl[0]});
      wait_b("bp_second");

      // R backpressure.
      rq.push_back({2'b00, mdl[0]});
      bus.S_AXI_ARADDR = 5'h0; bus.S_AXI_ARVALID = 1'b1;
      step();
      bus.S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("rbp_rvalid_held", 128'({bus.S_AXI_RVALID, bus.S_AXI_RDATA}), 128'({1'b1, 32'hA5}));
         chk("rbp_arready_low", 128'(bus.S_AXI_ARREADY), 128'(0));
         step();
      end
      pop_r("rbp");
      bus.S_AXI_RREADY = 1'b1;
      step();
      bus.S_AXI_RREADY = 1'b0;
      chk("rbp_released", 128'(bus.S_AXI_RVALID), 128'(0));

      // Back-to-back reads, one per cycle.
      bus.S_AXI_RREADY = 1'b1; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_ARADDR = 5'h0;
      for (int i = 0; i < 4; i++) begin
         rq.push_back({2'b00, mdl[i]});
         bus.S_AXI_ARADDR = 5'(4*i);
         chk("b2b_arready", 128'(bus.S_AXI_ARREADY), 128'(1));
         step();
         chk("b2b_rvalid", 128'(bus.S_AXI_RVALID), 128'(1));
         pop_r("b2b");
      end
      bus.S_AXI_ARVALID = 1'b0;
      step();
      bus.S_AXI_RREADY = 1'b0;

      // Reset after AW, before W.
      bus.S_AXI_AWADDR = 5'h0; bus.S_AXI_AWVALID = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mrst_readies", 128'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 128'(3'b111));
      chk("mrst_bvalid", 128'(bus.S_AXI_BVALID), 128'(0));
      chk("mrst_reg_out", reg_out, 128'(0));
      for (int i = 0; i < 4; i++) mdl[i] = '0;
      step(); step();
      rst_n = 1'b1;
      step(); step();
      chk("mrst_no_stale_b", 128'(bus.S_AXI_BVALID), 128'(0));
      axi_write("mrst_wr", 5'h0, 32'h5, 4'hF);
      chk("mrst_reg0", reg_out, 128'h5);

      // Out-of-range address bit 4.
      axi_write("oor_wr", 5'h10, 32'h9, 4'hF);
      chk("oor_reg0", reg_out[31:0], 128'(mdl[0]));
      axi_read("oor_rd", 5'h14);

      chk("scoreboards_drained", 128'({bq.size() == 0, rq.size() == 0}), 128'(2'b11));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end
endmodule
